// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative radix-2 shift-add multiply / restoring divide unit
// Defining MULDIV_SIGNED_EN adds signed operation selected by op[2]; otherwise all ops are unsigned.

module muldiv_unit #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [2:0]            op,
   input  logic [DATA_WIDTH-1:0] SrcA,
   input  logic [DATA_WIDTH-1:0] SrcB,
   input  logic                  flush,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] Result
);
   localparam int W = DATA_WIDTH;
   localparam int CNT_WIDTH = $clog2(DATA_WIDTH) + 1;
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DATA_WIDTH);

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t               state_q;
   logic                 busy_q, done_q, neg_q;
   logic [1:0]           kind_q;
   logic [CNT_WIDTH-1:0] cnt_q;
   logic [W-1:0]         opnd_q, hi_q, lo_q, result_q;

   logic                 a_neg, b_neg, div_ovf, div_zero, neg_res;
   logic [W-1:0]         mag_a, mag_b, quick_res;

`ifdef MULDIV_SIGNED_EN
   localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};
   assign a_neg   = op[2] & SrcA[W-1];
   assign b_neg   = op[2] & SrcB[W-1];
   assign mag_a   = a_neg ? -SrcA : SrcA;
   assign mag_b   = b_neg ? -SrcB : SrcB;
   assign div_ovf = op[2] & op[1] & (SrcA == MOST_NEG) & (SrcB == '1);
`else
   logic unused_sign;
   assign unused_sign = op[2];
   assign a_neg   = 1'b0;
   assign b_neg   = 1'b0;
   assign mag_a   = SrcA;
   assign mag_b   = SrcB;
   assign div_ovf = 1'b0;
`endif

   // Remainder follows the dividend's sign; product and quotient follow the xor.
   assign neg_res   = (op[1:0] == 2'b11) ? a_neg : (a_neg ^ b_neg);
   assign div_zero  = op[1] & (SrcB == '0);
   assign quick_res = div_zero ? (op[0] ? SrcA : '1) : (op[0] ? '0 : SrcA);

   logic [W:0]   mul_sum, div_shift, div_diff;
   logic [W-1:0] hi_d, lo_d;

   always_comb begin
      mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
      div_shift = {hi_q, lo_q[W-1]};
      div_diff  = div_shift - {1'b0, opnd_q};
      if (kind_q[1]) begin
         hi_d = div_diff[W] ? div_shift[W-1:0] : div_diff[W-1:0];
         lo_d = {lo_q[W-2:0], ~div_diff[W]};
      end else begin
         hi_d = mul_sum[W:1];
         lo_d = {mul_sum[0], lo_q[W-1:1]};
      end
   end

   logic [2*W-1:0] prod_fix;
   logic [W-1:0]   div_mag, fin_res;

   always_comb begin
      prod_fix = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
      div_mag  = kind_q[0] ? hi_q : lo_q;
      if (kind_q[1]) fin_res = neg_q ? -div_mag : div_mag;
      else           fin_res = kind_q[0] ? prod_fix[2*W-1:W] : prod_fix[W-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         neg_q    <= 1'b0;
         kind_q   <= '0;
         cnt_q    <= '0;
         opnd_q   <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         result_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            RUN: begin
               if (flush) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else if (cnt_q == CNT_LAST) begin
                  state_q  <= FIN;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  result_q <= fin_res;
               end else begin
                  cnt_q <= cnt_q + CNT_WIDTH'(1);
                  hi_q  <= hi_d;
                  lo_q  <= lo_d;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               if (start && !flush) begin
                  kind_q <= op[1:0];
                  neg_q  <= neg_res;
                  cnt_q  <= '0;
                  if (div_zero || div_ovf) begin
                     // Answer is known from the operands alone; skip the iterations.
                     state_q  <= FIN;
                     done_q   <= 1'b1;
                     result_q <= quick_res;
                  end else begin
                     state_q <= RUN;
                     busy_q  <= 1'b1;
                     opnd_q  <= op[1] ? mag_b : mag_a;
                     hi_q    <= '0;
                     lo_q    <= op[1] ? mag_a : mag_b;
                  end
               end
            end
         endcase
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign Result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit (signed cases when MULDIV_SIGNED_EN is defined)

module tb_muldiv_unit;
   logic        clk, reset, start, flush;
   logic [2:0]  op;
   logic [31:0] SrcA, SrcB;
   logic        busy, done;
   logic [31:0] Result;

   int n_tests, n_fail, n_done, cyc;

   muldiv_unit #(.DATA_WIDTH(32)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .SrcA(SrcA), .SrcB(SrcB),
      .flush(flush), .busy(busy), .done(done), .Result(Result)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   // Reference arithmetic; quick is set when the answer arrives without iterating.
   function automatic void ref_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] v, output bit quick);
      logic [63:0] p;
      longint      sp;
      bit          sg;
      sg = 1'b0;
`ifdef MULDIV_SIGNED_EN
      sg = o[2];
`endif
      quick = 1'b0;
      v = '0;
      case (o[1:0])
         2'b00, 2'b01: begin
            if (sg) begin
               sp = longint'($signed(a)) * longint'($signed(b));
               p = sp;
            end else begin
               p = {32'b0, a} * {32'b0, b};
            end
            v = o[0] ? p[63:32] : p[31:0];
         end
         2'b10: begin
            if (b == 0) begin v = '1; quick = 1'b1; end
            else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin v = a; quick = 1'b1; end
            else if (sg) v = $signed(a) / $signed(b);
            else v = a / b;
         end
         default: begin
            if (b == 0) begin v = a; quick = 1'b1; end
            else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin v = '0; quick = 1'b1; end
            else if (sg) v = $signed(a) % $signed(b);
            else v = a % b;
         end
      endcase
   endfunction

   int          m_left;
   bit          m_busy, m_done, mon_en;
   logic [31:0] m_res, m_pend;

   always @(posedge clk) begin : model
      logic [31:0] v;
      bit          q;
      cyc++;
      if (reset) begin
         m_left = 0; m_busy = 0; m_done = 0; m_res = '0; mon_en = 1;
      end else begin
         m_done = 0;
         if (m_left > 0) begin
            if (flush) begin
               m_left = 0; m_busy = 0;
            end else begin
               m_left--;
               if (m_left == 0) begin m_done = 1; m_busy = 0; m_res = m_pend; end
            end
         end else if (start && !flush) begin
            ref_op(op, SrcA, SrcB, v, q);
            if (q) begin m_done = 1; m_res = v; end
            else begin m_left = 33; m_busy = 1; m_pend = v; end
         end
      end
   end

   always @(negedge clk) begin
      if (mon_en) begin
         chk("mon_busy", 32'(busy), 32'(m_busy));
         chk("mon_done", 32'(done), 32'(m_done));
         chk("mon_result", Result, m_res);
         chk("mon_busy_and_done", 32'(busy & done), 32'd0);
         if (done) n_done++;
      end
   end

   task automatic wait_done(input string nm, output bit seen);
      seen = 1'b0;
      for (int k = 0; k < 60; k++) begin
         if (done) begin seen = 1'b1; break; end
         @(negedge clk);
      end
      chk({nm, "_timeout"}, 32'(seen), 32'd1);
   endtask

   task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int exp_lat, input string nm);
      int c0;
      bit seen;
      @(negedge clk);
      start = 1'b1; op = o; SrcA = a; SrcB = b; c0 = cyc;
      @(negedge clk);
      start = 1'b0;
      wait_done(nm, seen);
      if (seen) begin
         chk({nm, "_latency"}, 32'(cyc - c0 - 1), 32'(exp_lat));
         chk({nm, "_value"}, Result, exp);
      end
      @(negedge clk);
   endtask

   initial begin : stim
      int  c0, c1, nd;
      bit  seen;
      n_tests = 0; n_fail = 0; n_done = 0; cyc = 0; mon_en = 0;
      reset = 1'b1; start = 1'b0; flush = 1'b0; op = '0; SrcA = '0; SrcB = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_result", Result, 32'd0);

      // Reset in the middle of a multiply
      start = 1'b1; op = 3'b000; SrcA = 7; SrcB = 6;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("midrun_reset_busy", 32'(busy), 32'd0);
      nd = n_done;
      repeat (40) @(negedge clk);
      chk("midrun_reset_no_done", 32'(n_done), 32'(nd));
      chk("midrun_reset_result", Result, 32'd0);
      run_op(3'b000, 7, 6, 32'd42, 33, "mul_7x6");

      run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulh_ones");
      run_op(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33, "mul_ones");
      run_op(3'b000, 0, 32'h1234_5678, 32'd0, 33, "mul_zero");
      run_op(3'b010, 100, 7, 32'd14, 33, "div_100_7");
      run_op(3'b011, 100, 7, 32'd2, 33, "rem_100_7");
      run_op(3'b010, 32'h1234, 0, 32'hFFFF_FFFF, 0, "div_by_zero");
      run_op(3'b011, 32'h1234, 0, 32'h0000_1234, 0, "rem_by_zero");
      run_op(3'b010, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 33, "div_max_1");

      // Start held for three cycles, stray start during RUN, then a new op issued in FIN
      @(negedge clk);
      start = 1'b1; op = 3'b010; SrcA = 9; SrcB = 3; c0 = cyc;
      @(negedge clk);
      SrcA = 99;
      @(negedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      start = 1'b1; op = 3'b000; SrcA = 2; SrcB = 2;
      @(negedge clk);
      start = 1'b0;
      wait_done("b2b_div", seen);
      if (seen) begin
         chk("b2b_div_latency", 32'(cyc - c0 - 1), 32'd33);
         chk("b2b_div_value", Result, 32'd3);
         start = 1'b1; op = 3'b000; SrcA = 5; SrcB = 5; c1 = cyc;
         @(negedge clk);
         start = 1'b0;
         chk("b2b_fin_accept_busy", 32'(busy), 32'd1);
         wait_done("b2b_mul", seen);
         if (seen) begin
            chk("b2b_mul_latency", 32'(cyc - c1 - 1), 32'd33);
            chk("b2b_mul_value", Result, 32'd25);
         end
      end
      @(negedge clk);

      // Flush partway through a divide
      start = 1'b1; op = 3'b010; SrcA = 50; SrcB = 5;
      @(negedge clk);
      start = 1'b0;
      repeat (18) @(negedge clk);
      chk("flush_busy_before", 32'(busy), 32'd1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_busy_after", 32'(busy), 32'd0);
      nd = n_done;
      repeat (40) @(negedge clk);
      chk("flush_no_done", 32'(n_done), 32'(nd));
      chk("flush_result_kept", Result, 32'd25);

      // Start together with flush in IDLE is dropped
      start = 1'b1; flush = 1'b1; op = 3'b000; SrcA = 3; SrcB = 3;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      chk("idle_flush_busy", 32'(busy), 32'd0);
      nd = n_done;
      repeat (40) @(negedge clk);
      chk("idle_flush_no_done", 32'(n_done), 32'(nd));

`ifdef MULDIV_SIGNED_EN
      run_op(3'b110, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFD, 33, "sdiv_m7_2");
      run_op(3'b111, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFF, 33, "srem_m7_2");
      run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, "sdiv_ovf");
      run_op(3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0, "srem_ovf");
      run_op(3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33, "smulh_m1_m1");
      run_op(3'b110, 32'hFFFF_FFF9, 0, 32'hFFFF_FFFF, 0, "sdiv_by_zero");
`else
      run_op(3'b110, 32'hFFFF_FFF9, 2, 32'h7FFF_FFFC, 33, "udiv_opflag_ignored");
      run_op(3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "umulh_opflag_ignored");
`endif

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
